// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU codes,
// opcode/func values and datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StWbR     = 4'd3,
    StExecI   = 4'd4,
    StWbI     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13,
    StTrap    = 4'd14,
    StReset   = 4'd15
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSll = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0110;
  localparam logic [3:0] AluSra = 4'b0111;
  localparam logic [3:0] AluLui = 4'b1000;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;
  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDst31 = 2'd2;

  localparam logic [1:0] MemtoRegAlu = 2'd0;
  localparam logic [1:0] MemtoRegMdr = 2'd1;
  localparam logic [1:0] MemtoRegPc  = 2'd2;

  localparam logic [1:0] SrcAPc    = 2'd0;
  localparam logic [1:0] SrcARs    = 2'd1;
  localparam logic [1:0] SrcAShamt = 2'd2;

  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRs     = 2'd3;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational (op, func) decode: ALU operation, immediate extension,
// shift flag and instruction legality.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [3:0] o_alu_ctr,
  output logic       o_ext_op,
  output logic       o_is_shift,
  output logic       o_legal
);

  always_comb begin
    o_alu_ctr  = AluAdd;
    o_ext_op   = 1'b0;
    o_is_shift = 1'b0;
    o_legal    = 1'b1;
    case (i_op)
      OpRtype: begin
        case (i_func)
          FnAdd: o_alu_ctr = AluAdd;
          FnSub: o_alu_ctr = AluSub;
          FnAnd: o_alu_ctr = AluAnd;
          FnOr:  o_alu_ctr = AluOr;
          FnXor: o_alu_ctr = AluXor;
          FnSll: begin o_alu_ctr = AluSll; o_is_shift = 1'b1; end
          FnSrl: begin o_alu_ctr = AluSrl; o_is_shift = 1'b1; end
          FnSra: begin o_alu_ctr = AluSra; o_is_shift = 1'b1; end
          FnJr:  o_alu_ctr = AluAdd;
          default: o_legal = 1'b0;
        endcase
      end
      OpAddi: begin o_alu_ctr = AluAdd; o_ext_op = 1'b1; end
      OpAndi: o_alu_ctr = AluAnd;
      OpOri:  o_alu_ctr = AluOr;
      OpXori: o_alu_ctr = AluXor;
      OpLui:  o_alu_ctr = AluLui;
      OpLw, OpSw: o_ext_op = 1'b1;
      OpBeq, OpBne: begin o_alu_ctr = AluSub; o_ext_op = 1'b1; end
      OpJ, OpJal: o_alu_ctr = AluAdd;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences the shared memory port, ALU and
// PC/IR/ALUOut registers, driving every datapath select and write strobe.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUctr,
  output logic [1:0] PCSrc,
  output logic       Extop,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     r_state;
  state_e     w_state_next;
  logic       r_illegal;
  logic [3:0] w_alu_ctr;
  logic       w_ext_op;
  logic       w_is_shift;
  logic       w_legal;

  mc_alu_decode u_alu_decode (
    .i_op       (op),
    .i_func     (func),
    .o_alu_ctr  (w_alu_ctr),
    .o_ext_op   (w_ext_op),
    .o_is_shift (w_is_shift),
    .o_legal    (w_legal)
  );

  // Async reset drops every strobe at once, cancelling in-flight writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StReset;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= r_illegal | (w_state_next == StTrap);
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;

  always_comb begin
    w_state_next = r_state;
    PCWr     = 1'b0;
    IorD     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = RegDstRt;
    MemtoReg = MemtoRegAlu;
    ALUSrcA  = SrcAPc;
    ALUSrcB  = SrcBRt;
    ALUctr   = AluAdd;
    PCSrc    = PcSrcAlu;
    Extop    = 1'b0;
    unique case (r_state)
      StReset: w_state_next = StFetch;
      StFetch: begin
        MemRd = 1'b1;
        if (mem_ready) begin
          IRWr         = 1'b1;
          PCWr         = 1'b1;
          ALUSrcB      = SrcBFour;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh;
        Extop   = 1'b1;
        case (op)
          OpRtype: begin
            if (!w_legal)           w_state_next = StTrap;
            else if (func == FnJr)  w_state_next = StJr;
            else                    w_state_next = StExecR;
          end
          OpAddi, OpAndi, OpOri, OpXori, OpLui: w_state_next = StExecI;
          OpLw, OpSw:   w_state_next = StMemAddr;
          OpBeq, OpBne: w_state_next = StBranch;
          OpJ:          w_state_next = StJump;
          OpJal:        w_state_next = StJal;
          default:      w_state_next = StTrap;
        endcase
      end
      StExecR: begin
        ALUSrcA      = w_is_shift ? SrcAShamt : SrcARs;
        ALUctr       = w_alu_ctr;
        w_state_next = StWbR;
      end
      StWbR: begin
        RegWr        = 1'b1;
        RegDst       = RegDstRd;
        w_state_next = StFetch;
      end
      StExecI: begin
        ALUSrcA      = SrcARs;
        ALUSrcB      = SrcBImm;
        ALUctr       = w_alu_ctr;
        Extop        = w_ext_op;
        w_state_next = StWbI;
      end
      StWbI: begin
        RegWr        = 1'b1;
        w_state_next = StFetch;
      end
      StMemAddr: begin
        ALUSrcA      = SrcARs;
        ALUSrcB      = SrcBImm;
        Extop        = 1'b1;
        w_state_next = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD  = 1'b1;
        MemRd = 1'b1;
        if (mem_ready) w_state_next = StMemWb;
      end
      StMemWb: begin
        RegWr        = 1'b1;
        MemtoReg     = MemtoRegMdr;
        w_state_next = StFetch;
      end
      StMemWr: begin
        IorD  = 1'b1;
        MemWr = 1'b1;
        if (mem_ready) w_state_next = StFetch;
      end
      StBranch: begin
        ALUSrcA      = SrcARs;
        ALUctr       = AluSub;
        PCSrc        = PcSrcAluOut;
        PCWr         = (op == OpBeq) ? zero : ~zero;
        w_state_next = StFetch;
      end
      StJump: begin
        PCWr         = 1'b1;
        PCSrc        = PcSrcJump;
        w_state_next = StFetch;
      end
      StJal: begin
        PCWr         = 1'b1;
        PCSrc        = PcSrcJump;
        RegWr        = 1'b1;
        RegDst       = RegDst31;
        MemtoReg     = MemtoRegPc;
        w_state_next = StFetch;
      end
      StJr: begin
        PCWr         = 1'b1;
        PCSrc        = PcSrcRs;
        w_state_next = StFetch;
      end
      StTrap: w_state_next = StTrap;
    endcase
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the MIPS CPU. It replaces the single-cycle decoder with a state machine that sequences one shared memory port, one ALU and the PC/IR/ALUOut registers across several clocks per instruction. It sits between the instruction register (op/func), the ALU zero flag and the memory ready handshake, and drives every datapath mux select and write strobe. The supported ISA is add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lui, lw, sw, beq, bne, j and jal.

## Interface
- No parameters. All encodings come from the shared package.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWr  out  1  PC write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRd  out  1  memory read request.
- MemWr  out  1  memory write request.
- IRWr  out  1  instruction register load.
- RegWr  out  1  register file write.
- RegDst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31.
- MemtoReg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- ALUSrcA  out  2  ALU A select: 0 = PC, 1 = rs, 2 = shamt.
- ALUSrcB  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = ext(imm), 3 = ext(imm)<<2.
- ALUctr  out  4  ALU operation.
- PCSrc  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], target, 00}, 3 = rs.
- Extop  out  1  immediate extension: 1 = sign, 0 = zero.
- illegal  out  1  unsupported op or func has been decoded; sticky.
- state  out  4  current state, for debug.

## Operation
- ALUctr codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, LUI 1000.
- Outputs are decoded combinationally from the registered state. The only exceptions are the FETCH strobes, which are gated by mem_ready, and PCWr in BRANCH, which is gated by zero.
- Every output not listed for a state is 0.
- States and transitions:
  - RESET(15): all outputs 0. Goes to FETCH on the next edge.
  - FETCH(0): MemRd=1, IorD=0. Stays in FETCH while mem_ready=0. When mem_ready=1 it also asserts IRWr, PCWr, ALUSrcA=0, ALUSrcB=1, ALUctr=ADD, PCSrc=0, and goes to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, ADD, Extop=1, which latches the branch target into ALUOut. Next state by opcode:
    - R-type with a legal func other than jr goes to EXEC_R.
    - jr goes to JR.
    - addi, andi, ori, xori and lui go to EXEC_I.
    - lw and sw go to MEM_ADDR.
    - beq and bne go to BRANCH.
    - j goes to JUMP.
    - jal goes to JAL.
    - Anything else goes to TRAP.
  - EXEC_R(2): ALUSrcA=2 for sll/srl/sra, else 1. ALUSrcB=0. ALUctr comes from func. Goes to WB_R.
  - WB_R(3): RegWr=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - EXEC_I(4): ALUSrcA=1, ALUSrcB=2. ALUctr is ADD, AND, OR, XOR or LUI according to op. Extop=1 only for addi. Goes to WB_I.
  - WB_I(5): RegWr=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - MEM_ADDR(6): ALUSrcA=1, ALUSrcB=2, ADD, Extop=1. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(7): IorD=1, MemRd=1. Stays until mem_ready=1, then goes to MEM_WB.
  - MEM_WB(8): RegWr=1, RegDst=0, MemtoReg=1. Goes to FETCH.
  - MEM_WR(9): IorD=1, MemWr=1. Stays until mem_ready=1, then goes to FETCH.
  - BRANCH(10): ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=1. PCWr=(beq&zero)|(bne&~zero). Goes to FETCH.
  - JUMP(11): PCWr=1, PCSrc=2. Goes to FETCH.
  - JAL(12): PCWr=1, PCSrc=2, RegWr=1, RegDst=2, MemtoReg=2. $31 receives the old PC, which already holds PC+4. Goes to FETCH.
  - JR(13): PCWr=1, PCSrc=3. Goes to FETCH.
  - TRAP(14): illegal=1, all strobes 0. Stays in TRAP until reset.
- Memory handshake:
  - MemRd or MemWr, together with IorD, stays stable from the first cycle of the access state until the cycle in which mem_ready=1 is sampled.
  - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- Reset: asserting rst_n=0 forces state=RESET and illegal=0 immediately. All outputs are 0 during reset, including when reset hits mid-instruction.
- Memory writes and PC writes are cancelled if reset asserts in the same cycle.
- The first FETCH begins on the first clk edge after rst_n rises.
- Latency in clocks, with w = memory wait cycles per access:
  - R-type and I-type ALU ops: 4+w.
  - lw: 5+2w.
  - sw: 4+2w.
  - beq/bne, j, jal and jr: 3+w.
  - Illegal instructions: 2+w to reach TRAP.
- An illegal func under op=000000 traps exactly as an illegal op does.

## Structure
- Package mc_pkg holds:
  - state encoding
  - ALUctr codes
  - opcode and func constants
  - RegDst, MemtoReg, ALUSrcA, ALUSrcB and PCSrc select codes
- Sub-module mc_alu_decode is a combinational block. It maps (op, func) to ALUctr, Extop, is_shift and legal, and is used by EXEC_R, EXEC_I and the DECODE dispatch.
- mc_control holds the state register plus the next-state and output logic.

## Test plan
- Reset, then mem_ready tied to 1, add (op 000000, func 100000): the state sequence is 0,1,2,3,0. WB_R has RegWr=1, RegDst=1, MemtoReg=0. EXEC_R has ALUctr=0000.
- lw (100011) with mem_ready low for 2 cycles in each access: MemRd is held for 3 cycles in FETCH and 3 cycles in MEM_RD, with IorD=1 in MEM_RD. Total 9 clocks.
- beq (000100) with zero=1: PCWr=1, PCSrc=1 in BRANCH. With zero=0, PCWr=0. bne (000101) gives the opposite result.
- jal (000011): JAL state has PCWr=1, PCSrc=2, RegWr=1, RegDst=2, MemtoReg=2. jr (func 001000) has PCSrc=3 and RegWr=0.
- op=111111, or op=000000 with func=111111: state reaches 14, illegal=1, and no strobes fire for 20 cycles. rst_n=0 clears illegal.
- sw (101011) with rst_n pulsed low during MEM_WR: MemWr drops to 0 immediately, state=RESET, then FETCH on the next edge after release.
